reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised successor to the datapath register file.
- Configurable data width, register count and number of read ports.
- Registered (1-cycle) reads, address-range checking and a sequenced clear engine that zeroes the array one entry per cycle.
- Sits between the bus and the ALU/address adders; the control unit supplies decoded DR/SR addresses directly.

Parameters:
- WIDTH, 16, data width of each register and of bus/read outputs.
- DEPTH, 8, number of registers (2..64, need not be a power of two).
- NRD, 2, number of independent read ports (1..4).
- AW, $clog2(DEPTH), address width (derived, not overridden).
- ZERO_R0, 0, when 1 register 0 always reads 0 and ignores writes.

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- LD_REG  in  1  write enable for DR.
- DR  in  AW  write address.
- bus  in  WIDTH  write data.
- SR  in  NRD*AW  read addresses, port k at [k*AW +: AW].
- SR_OUT  out  NRD*WIDTH  registered read data, port k at [k*WIDTH +: WIDTH].
- CLR_REQ  in  1  start sequenced clear (level, sampled in IDLE only).
- CLR_BUSY  out  1  high while clear engine runs.
- CLR_DONE  out  1  one-cycle pulse after last entry cleared.
- WR_DROP  out  1  one-cycle pulse when a write was discarded (busy or out-of-range DR).

Behaviour:
- Reset (Reset_n low, asynchronous): all registers = 0, SR_OUT = 0, CLR_BUSY = 0, CLR_DONE = 0, WR_DROP = 0, FSM = IDLE, clear counter = 0.
- Write: on posedge, if LD_REG and FSM = IDLE and DR < DEPTH (and not (ZERO_R0 and DR = 0)), then reg[DR] <= bus.
- Write drop: LD_REG with CLR_BUSY = 1 or DR >= DEPTH writes nothing and pulses WR_DROP on the next cycle.
  - LD_REG with ZERO_R0 and DR = 0 is silently ignored, with no WR_DROP.
- Read: each posedge, SR_OUT[k] <= reg[SR[k]], giving 1-cycle latency.
  - SR[k] >= DEPTH returns 0.
  - With ZERO_R0, SR[k] = 0 returns 0.
  - Ports are independent; the same address on several ports is legal.
- Same-cycle write and read to one address: the read returns the old contents; see the optional feature for forwarding.
- Clear FSM states:
  - IDLE: if CLR_REQ, then counter <= 0, CLR_BUSY <= 1, go to CLEAR.
  - CLEAR: reg[counter] <= 0 and counter++. When counter = DEPTH-1, go to DONE.
  - DONE: CLR_DONE = 1 for one cycle, CLR_BUSY <= 0, go to IDLE.
  - CLR_REQ still high in DONE/IDLE restarts the clear on the following cycle. No queueing beyond that.
- Clear timing: CLR_BUSY is asserted the cycle after CLR_REQ is sampled and stays high for DEPTH+1 cycles (DEPTH in CLEAR plus 1 in DONE).
- Reads during clear are permitted and return current array contents (partially cleared).
- Reset mid-clear aborts immediately; all state returns to reset values.
- Counter is AW bits wide. For non-power-of-two DEPTH, it never exceeds DEPTH-1 (no wrap into unused codes).

Optional Feature:
- Macro: REG_FILE_MP_FWD_EN.
- Defined: on a read with LD_REG accepted (write not dropped) and DR = SR[k] in the same cycle, SR_OUT[k] <= bus (write-through bypass). Applied per port.
- Not defined: the read returns the pre-write value, and the new value is visible one cycle later.
- Forwarding never overrides ZERO_R0 or out-of-range zeroing.

Test Plan:
- Reset, then write bus = 16'h1234 to DR = 3, then SR[0] = 3 the next cycle -> SR_OUT[0] = 16'h1234 one cycle after the address is applied; other registers read 0.
- Same cycle LD_REG, DR = 5, bus = 16'hBEEF, SR[1] = 5, with reg5 = 16'h0001 -> without the macro SR_OUT[1] = 16'h0001 then 16'hBEEF; with REG_FILE_MP_FWD_EN, SR_OUT[1] = 16'hBEEF immediately.
- Fill all 8 registers with 16'hFFFF, pulse CLR_REQ -> CLR_BUSY high for 9 cycles, CLR_DONE pulses once, all reads return 0; an LD_REG during busy produces a WR_DROP pulse and no write.
- DEPTH = 6, write DR = 7 with bus = 16'hAAAA -> WR_DROP pulse; SR = 7 reads 0; regs 0..5 unchanged.
- ZERO_R0 = 1: write DR = 0 with 16'h5555 -> SR_OUT = 0 and no WR_DROP. Both ports reading DR = 2 (value 16'h00C3) -> both ports output 16'h00C3.
- Assert Reset_n low mid-clear (after 3 entries cleared), release -> CLR_BUSY = 0, all regs 0, FSM in IDLE, no CLR_DONE pulse.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with registered reads, address-range checks and a sequenced clear engine.
// Optional write-through read bypass is enabled by defining REG_FILE_MP_FWD_EN.
module reg_file_mp #(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 8,
   parameter int NRD     = 2,
   parameter int AW      = $clog2(DEPTH),
   parameter int ZERO_R0 = 0
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   input  logic                 LD_REG,
   input  logic [AW-1:0]        DR,
   input  logic [WIDTH-1:0]     bus,
   input  logic [NRD*AW-1:0]    SR,
   output logic [NRD*WIDTH-1:0] SR_OUT,
   input  logic                 CLR_REQ,
   output logic                 CLR_BUSY,
   output logic                 CLR_DONE,
   output logic                 WR_DROP
);

   localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DONE} state_t;

   state_t            state, state_nxt;
   logic [AW-1:0]     cnt, cnt_nxt;
   logic              done_nxt;
   logic              wr_in_range, wr_acc, drop_nxt, clr_we;
   logic [WIDTH-1:0]  mem [DEPTH];
   logic [WIDTH-1:0]  rd_nxt [NRD];

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      done_nxt  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (CLR_REQ) begin
               state_nxt = ST_CLEAR;
               cnt_nxt   = '0;
            end
         end
         ST_CLEAR: begin
            // Counter parks on the last entry so it never enters unused codes.
            if (cnt == LAST) begin
               state_nxt = ST_DONE;
               done_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   assign clr_we      = (state == ST_CLEAR);
   assign wr_in_range = ({1'b0, DR} < DEPTH_C);
   assign wr_acc      = LD_REG && (state == ST_IDLE) && wr_in_range &&
                        !((ZERO_R0 != 0) && (DR == '0));
   assign drop_nxt    = LD_REG && ((state != ST_IDLE) || !wr_in_range);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         CLR_BUSY <= 1'b0;
         CLR_DONE <= 1'b0;
         WR_DROP  <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         CLR_BUSY <= (state_nxt != ST_IDLE);
         CLR_DONE <= done_nxt;
         WR_DROP  <= drop_nxt;
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_reg
      always_ff @(posedge Clk or negedge Reset_n) begin
         if (!Reset_n)
            mem[i] <= '0;
         else if (clr_we && (cnt == AW'(i)))
            mem[i] <= '0;
         else if (wr_acc && (DR == AW'(i)))
            mem[i] <= bus;
      end
   end

   always_comb begin
      logic [AW-1:0] a;
      for (int k = 0; k < NRD; k++) begin
         a         = SR[k*AW +: AW];
         rd_nxt[k] = '0;
         // Out-of-range and hard-wired zero win over the bypass.
         if (({1'b0, a} < DEPTH_C) && !((ZERO_R0 != 0) && (a == '0))) begin
            rd_nxt[k] = mem[a];
`ifdef REG_FILE_MP_FWD_EN
            if (wr_acc && (DR == a))
               rd_nxt[k] = bus;
`endif
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         SR_OUT <= '0;
      end else begin
         for (int k = 0; k < NRD; k++)
            SR_OUT[k*WIDTH +: WIDTH] <= rd_nxt[k];
      end
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp: default instance plus a DEPTH=6 / ZERO_R0=1 instance.
module tb_reg_file_mp;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;

   logic        a_ld = 1'b0, a_clr = 1'b0;
   logic [2:0]  a_dr = '0;
   logic [15:0] a_bus = '0;
   logic [5:0]  a_sr = '0;
   logic [31:0] a_out;
   logic        a_busy, a_done, a_drop;

   logic        b_ld = 1'b0, b_clr = 1'b0;
   logic [2:0]  b_dr = '0;
   logic [15:0] b_bus = '0;
   logic [5:0]  b_sr = '0;
   logic [31:0] b_out;
   logic        b_busy, b_done, b_drop;

   int n_checks = 0;
   int n_errors = 0;

   always #5 Clk = ~Clk;

   reg_file_mp #(.WIDTH(16), .DEPTH(8), .NRD(2), .ZERO_R0(0)) u_dut (
      .Clk(Clk), .Reset_n(Reset_n), .LD_REG(a_ld), .DR(a_dr), .bus(a_bus),
      .SR(a_sr), .SR_OUT(a_out), .CLR_REQ(a_clr), .CLR_BUSY(a_busy),
      .CLR_DONE(a_done), .WR_DROP(a_drop));

   reg_file_mp #(.WIDTH(16), .DEPTH(6), .NRD(2), .ZERO_R0(1)) u_dut6 (
      .Clk(Clk), .Reset_n(Reset_n), .LD_REG(b_ld), .DR(b_dr), .bus(b_bus),
      .SR(b_sr), .SR_OUT(b_out), .CLR_REQ(b_clr), .CLR_BUSY(b_busy),
      .CLR_DONE(b_done), .WR_DROP(b_drop));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic wr_a(input logic [2:0] dr, input logic [15:0] val);
      a_ld = 1'b1; a_dr = dr; a_bus = val;
      tick();
      a_ld = 1'b0;
   endtask

   task automatic wr_b(input logic [2:0] dr, input logic [15:0] val);
      b_ld = 1'b1; b_dr = dr; b_bus = val;
      tick();
      b_ld = 1'b0;
   endtask

   int busy_cnt, done_cnt, drop_cnt;

   initial begin
      // Reset state
      #8;
      check("rst_out",  a_out, 32'h0);
      check("rst_busy", a_busy, 1'b0);
      check("rst_done", a_done, 1'b0);
      check("rst_drop", a_drop, 1'b0);
      #4 Reset_n = 1'b1;
      tick();

      // Basic write then registered read
      wr_a(3'd3, 16'h1234);
      a_sr = {3'd4, 3'd3};
      tick();
      check("rd_p0_r3", a_out[15:0], 16'h1234);
      check("rd_p1_r4", a_out[31:16], 16'h0000);

      // Same-cycle write and read
      wr_a(3'd5, 16'h0001);
      a_ld = 1'b1; a_dr = 3'd5; a_bus = 16'hBEEF; a_sr = {3'd5, 3'd0};
      tick();
      a_ld = 1'b0;
`ifdef REG_FILE_MP_FWD_EN
      check("raw_same", a_out[31:16], 16'hBEEF);
`else
      check("raw_same", a_out[31:16], 16'h0001);
`endif
      tick();
      check("raw_next", a_out[31:16], 16'hBEEF);

      // Fill, then sequenced clear with a write attempted while busy
      for (int i = 0; i < 8; i++) wr_a(3'(i), 16'hFFFF);
      a_sr = {3'd0, 3'd7};
      tick();
      check("fill_r7", a_out[15:0], 16'hFFFF);
      a_clr = 1'b1;
      tick();
      a_clr = 1'b0;
      busy_cnt = a_busy ? 1 : 0;
      done_cnt = 0;
      drop_cnt = 0;
      for (int i = 0; i < 14; i++) begin
         if (i == 2) begin a_ld = 1'b1; a_dr = 3'd1; a_bus = 16'h1111; end
         else a_ld = 1'b0;
         tick();
         if (a_busy) busy_cnt++;
         if (a_done) done_cnt++;
         if (a_drop) drop_cnt++;
      end
      check("clr_busy_cycles", busy_cnt, 9);
      check("clr_done_pulses", done_cnt, 1);
      check("clr_drop_pulses", drop_cnt, 1);
      for (int i = 0; i < 8; i++) begin
         a_sr = {3'(7 - i), 3'(i)};
         tick();
         check("clr_rd", a_out, 32'h0);
      end

      // Reset in the middle of a clear
      for (int i = 0; i < 8; i++) wr_a(3'(i), 16'hFFFF);
      a_clr = 1'b1;
      tick();
      a_clr = 1'b0;
      tick();
      tick();
      a_sr = {3'd5, 3'd0};
      tick();
      check("mid_busy", a_busy, 1'b1);
      check("mid_partial", a_out, {16'hFFFF, 16'h0000});
      Reset_n = 1'b0;
      #1;
      check("abort_busy", a_busy, 1'b0);
      check("abort_out", a_out, 32'h0);
      #2 Reset_n = 1'b1;
      busy_cnt = 0;
      done_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (a_busy) busy_cnt++;
         if (a_done) done_cnt++;
      end
      check("abort_no_busy", busy_cnt, 0);
      check("abort_no_done", done_cnt, 0);
      for (int i = 0; i < 4; i++) begin
         a_sr = {3'(2 * i + 1), 3'(2 * i)};
         tick();
         check("abort_rd", a_out, 32'h0);
      end
      wr_a(3'd2, 16'h2222);
      check("idle_drop", a_drop, 1'b0);
      a_sr = {3'd2, 3'd2};
      tick();
      check("idle_wr", a_out, {16'h2222, 16'h2222});

      // DEPTH=6, ZERO_R0=1 instance
      for (int i = 1; i < 6; i++) wr_b(3'(i), 16'h0100 + 16'(i));
      wr_b(3'd2, 16'h00C3);
      check("b_inrange_drop", b_drop, 1'b0);
      wr_b(3'd7, 16'hAAAA);
      check("b_oob7_drop", b_drop, 1'b1);
      wr_b(3'd6, 16'hAAAA);
      check("b_oob6_drop", b_drop, 1'b1);
      wr_b(3'd0, 16'h5555);
      check("b_r0_nodrop", b_drop, 1'b0);
      b_sr = {3'd0, 3'd7};
      tick();
      check("b_rd_r0_oob7", b_out, 32'h0);
      b_sr = {3'd2, 3'd2};
      tick();
      check("b_both_r2", b_out, {16'h00C3, 16'h00C3});
      b_ld = 1'b1; b_dr = 3'd0; b_bus = 16'h5555; b_sr = {3'd6, 3'd0};
      tick();
      b_ld = 1'b0;
      check("b_r0_fwd_zero", b_out, 32'h0);
      for (int i = 1; i < 6; i++) begin
         b_sr = {3'd0, 3'(i)};
         tick();
         check("b_regs_kept", b_out[15:0], (i == 2) ? 16'h00C3 : 16'h0100 + 16'(i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
